// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between the memory stage and dmem_responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_xfer_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_xfer_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_xfer_size, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle big-endian data-memory responder, one transaction outstanding
// Optional feature macro: DMEM_ERR_CHECK_EN (size/alignment/range checking with rsp_err).
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [63:0] rdata_q;
  logic [15:0] cnt;

  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [3:0]  lat_size;

  logic [7:0]  mem [DEPTH_BYTES];

  logic        accept;
  logic        commit;
  logic        c_write;
  logic [63:0] c_addr;
  logic [63:0] c_wdata;
  logic [3:0]  c_size;
  logic        c_err;
  logic [3:0]  nbytes;
  logic [63:0] rd;
  logic [AW-1:0] baddr [8];
  logic [7:0]  wbyte [8];

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept = (state == IDLE) && ready_q && bus.req_valid;

  // With zero latency the commit happens on the accept edge, so it must use the live request.
  assign c_write = (LATENCY == 0) ? bus.req_write     : lat_write;
  assign c_addr  = (LATENCY == 0) ? bus.req_addr      : lat_addr;
  assign c_wdata = (LATENCY == 0) ? bus.req_wdata     : lat_wdata;
  assign c_size  = (LATENCY == 0) ? bus.req_xfer_size : lat_size;

  assign commit = reset_n &&
                  (((LATENCY == 0) && accept) || ((state == WAIT) && (cnt == 16'd1)));

`ifndef DMEM_ERR_CHECK_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^c_addr[63:AW];
`endif

  // Decode size, check legality, and form per-byte addresses, read data and write bytes.
  always_comb begin
    nbytes = 4'd8;
    c_err  = 1'b0;
    rd     = 64'd0;
`ifdef DMEM_ERR_CHECK_EN
    case (c_size)
      4'd1, 4'd2, 4'd4, 4'd8: nbytes = c_size;
      default:                c_err  = 1'b1;
    endcase
    if ((c_addr & (64'(nbytes) - 64'd1)) != 64'd0)
      c_err = 1'b1;
    if (({1'b0, c_addr} + 65'(nbytes)) > 65'(DEPTH_BYTES))
      c_err = 1'b1;
`else
    case (c_size)
      4'd1, 4'd2, 4'd4, 4'd8: nbytes = c_size;
      default:                nbytes = 4'd8;
    endcase
`endif
    for (int k = 0; k < 8; k++) begin
      // Each byte address wraps independently inside the array.
      baddr[k] = c_addr[AW-1:0] + AW'(k);
      wbyte[k] = 8'd0;
      if (4'(k) < nbytes) begin
        rd       = {rd[55:0], mem[baddr[k]]};
        wbyte[k] = 8'(c_wdata >> (8 * (int'(nbytes) - 1 - k)));
      end
    end
  end

  // Store commit: byte at the base address takes the most significant byte of the transfer.
  always_ff @(posedge clk) begin
    if (commit && c_write && !c_err) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes)
          mem[baddr[k]] <= wbyte[k];
      end
    end
  end

  // Control FSM with registered handshake outputs and response capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      cnt     <= 16'd0;
    end else begin
      if (commit) begin
        rdata_q <= (c_write || c_err) ? 64'd0 : rd;
        err_q   <= c_err;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_size  <= bus.req_xfer_size;
            cnt       <= 16'(LATENCY);
            ready_q   <= 1'b0;
            if (LATENCY == 0) begin
              state   <= RESP;
              valid_q <= 1'b1;
            end else begin
              state   <= WAIT;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state   <= RESP;
            valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
